// File: rtl/pueo_trig_pkg.sv
// Shared definitions for the PUEO trigger arbiter: source indices,
// metadata field layout, and the arbiter state encoding.
package pueo_trig_pkg;

   localparam int NSRC     = 3;
   localparam int SRC_SOFT = 0;
   localparam int SRC_PPS  = 1;
   localparam int SRC_EXT  = 2;

   localparam int ADDR_W   = 12;

   localparam int META_W       = 8;
   localparam int META_SRC_LSB = 0;
   localparam int META_SRC_W   = 3;
   localparam int META_SEQ_LSB = 3;
   localparam int META_SEQ_W   = 5;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } trig_state_t;

   // Advance a round-robin source index, wrapping ext back to soft.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'(SRC_EXT)) ? 2'(SRC_SOFT) : idx + 2'd1;
   endfunction

endpackage

// File: rtl/pueo_trig_src_pend.sv
// One source's pending flag with drop detection. A request while the
// flag is already set (and not being granted this cycle) is a drop.
module pueo_trig_src_pend (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic en_i,
   input  logic running_i,
   input  logic grant_i,
   output logic pend_o,
   output logic drop_o
);

   logic pend_q;
   logic pend_d;
   logic accept;

   // Next pending state; disable or stop wipes the flag on the next edge.
   always_comb begin
      accept = req_i & en_i & running_i;
      pend_d = en_i & running_i & ((pend_q & ~grant_i) | accept);
      drop_o = accept & pend_q & ~grant_i;
   end

   // Pending flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pend_q <= 1'b0;
      else       pend_q <= pend_d;
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/pueo_trig_arbiter.sv
// PUEO trigger arbiter: collects soft/PPS/external trigger requests,
// grants them round-robin on TURF issue slots, and enforces a holdoff
// between issued triggers.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   STOPPED | run inactive; no grants, pending flags held clear
//   ARMED   | grant on next slot_ce_i if any source is pending
//   HOLDOFF | counting down holdoff after a grant; no grants
module pueo_trig_arbiter
   import pueo_trig_pkg::*;
#(
   parameter int HOLDOFF_W = 16,
   parameter int CNT_W     = 16
) (
   input  logic                 sysclk_i,
   input  logic                 sysclk_rst_i,
   input  logic                 slot_ce_i,
   input  logic                 running_i,
   input  logic [ADDR_W-1:0]    cur_addr_i,
   input  logic                 soft_req_i,
   input  logic                 pps_req_i,
   input  logic                 ext_req_i,
   input  logic [NSRC-1:0]      src_enable_i,
   input  logic [ADDR_W-1:0]    common_offset_i,
   input  logic [ADDR_W-1:0]    soft_offset_i,
   input  logic [ADDR_W-1:0]    pps_offset_i,
   input  logic [ADDR_W-1:0]    ext_offset_i,
   input  logic [HOLDOFF_W-1:0] holdoff_i,
   output logic [ADDR_W-1:0]    turf_trig_o,
   output logic [META_W-1:0]    turf_metadata_o,
   output logic                 turf_valid_o,
   output logic [CNT_W-1:0]     drop_count_o
);

   trig_state_t            state_q;
   logic [HOLDOFF_W-1:0]   hold_cnt_q;
   logic [1:0]             rr_q;
   logic [META_SEQ_W-1:0]  seq_q;
   logic                   valid_q;
   logic [ADDR_W-1:0]      trig_q;
   logic [META_W-1:0]      meta_q;
   logic [CNT_W-1:0]       drop_q;

   logic [NSRC-1:0]        req_v;
   logic [NSRC-1:0]        pend_v;
   logic [NSRC-1:0]        drop_v;
   logic [NSRC-1:0]        grant_v;

   logic                   gnt_found;
   logic [1:0]             gnt_idx;
   logic [1:0]             cand;
   logic                   cand_pend;
   logic                   grant_fire;
   logic [ADDR_W-1:0]      sel_off;
   logic [ADDR_W-1:0]      trig_d;
   logic [META_W-1:0]      meta_d;
   logic [1:0]             drop_sum;
   logic [CNT_W+1:0]       cnt_sum;
   logic [CNT_W-1:0]       drop_d;

   assign req_v = {ext_req_i, pps_req_i, soft_req_i};

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      pueo_trig_src_pend u_pend (
         .clk_i     (sysclk_i),
         .rst_i     (sysclk_rst_i),
         .req_i     (req_v[s]),
         .en_i      (src_enable_i[s]),
         .running_i (running_i),
         .grant_i   (grant_v[s]),
         .pend_o    (pend_v[s]),
         .drop_o    (drop_v[s])
      );
   end

   // Round-robin pick starting at rr_q, plus grant qualification and payload.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_q;
      cand      = rr_q;
      cand_pend = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         case (cand)
            2'd0:    cand_pend = pend_v[SRC_SOFT];
            2'd1:    cand_pend = pend_v[SRC_PPS];
            default: cand_pend = pend_v[SRC_EXT];
         endcase
         if (!gnt_found && cand_pend) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
         cand = rr_next(cand);
      end

      grant_fire = (state_q == ARMED) && running_i && slot_ce_i && gnt_found;
      grant_v    = grant_fire ? (NSRC'(1) << gnt_idx) : '0;

      case (gnt_idx)
         2'd0:    sel_off = soft_offset_i;
         2'd1:    sel_off = pps_offset_i;
         default: sel_off = ext_offset_i;
      endcase

      trig_d = cur_addr_i - common_offset_i - sel_off;
      meta_d = '0;
      meta_d[META_SRC_LSB +: META_SRC_W] = NSRC'(1) << gnt_idx;
      meta_d[META_SEQ_LSB +: META_SEQ_W] = seq_q;
   end

   // Saturating drop accumulation; up to three drops can land in one cycle.
   always_comb begin
      drop_sum = 2'(drop_v[0]) + 2'(drop_v[1]) + 2'(drop_v[2]);
      cnt_sum  = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_sum};
      drop_d   = (cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   // Arbiter FSM with registered trigger outputs.
   always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
      if (sysclk_rst_i) begin
         state_q    <= STOPPED;
         hold_cnt_q <= '0;
         rr_q       <= 2'(SRC_SOFT);
         seq_q      <= '0;
         valid_q    <= 1'b0;
         trig_q     <= '0;
         meta_q     <= '0;
         drop_q     <= '0;
      end else begin
         drop_q  <= drop_d;
         valid_q <= grant_fire;
         if (grant_fire) begin
            trig_q <= trig_d;
            meta_q <= meta_d;
            seq_q  <= seq_q + 1'b1;
            rr_q   <= rr_next(gnt_idx);
         end

         case (state_q)
            STOPPED: begin
               if (running_i) state_q <= ARMED;
            end
            ARMED: begin
               if (grant_fire && (holdoff_i != '0)) begin
                  state_q    <= HOLDOFF;
                  hold_cnt_q <= holdoff_i;
               end
            end
            HOLDOFF: begin
               // holdoff_i cycles are spent here; leave as the count hits zero
               if (hold_cnt_q <= HOLDOFF_W'(1)) begin
                  state_q    <= ARMED;
                  hold_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
            end
            default: state_q <= STOPPED;
         endcase

         if (!running_i) begin
            state_q    <= STOPPED;
            hold_cnt_q <= '0;
         end
      end
   end

   assign turf_valid_o    = valid_q;
   assign turf_trig_o     = trig_q;
   assign turf_metadata_o = meta_q;
   assign drop_count_o    = drop_q;

endmodule
